// File: rtl/qos_drain_sched_if.sv
// Response-in / drained-response-out bundle for qos_drain_sched, plus the
// upstream throttling status (pend_cnt, pend_max_qos).
interface qos_drain_sched_if #(
  parameter int ID_W   = 4,
  parameter int QOS_W  = 3,
  parameter int DATA_W = 8
);
  logic              in_vld;
  logic              in_rdy;
  logic [ID_W-1:0]   in_id;
  logic [QOS_W-1:0]  in_qos;
  logic [DATA_W-1:0] in_data;
  logic              out_vld;
  logic              out_rdy;
  logic [ID_W-1:0]   out_id;
  logic [QOS_W-1:0]  out_qos;
  logic [DATA_W-1:0] out_data;
  logic [ID_W:0]     pend_cnt;
  logic [QOS_W-1:0]  pend_max_qos;

  modport master (
    output in_vld, in_id, in_qos, in_data, out_rdy,
    input  in_rdy, out_vld, out_id, out_qos, out_data, pend_cnt, pend_max_qos
  );
  modport slave (
    input  in_vld, in_id, in_qos, in_data, out_rdy,
    output in_rdy, out_vld, out_id, out_qos, out_data, pend_cnt, pend_max_qos
  );
endinterface

// File: rtl/qos_drain_sched.sv
// Per-ID response table drained highest-QoS-first (ties: lowest ID).
// Optional QOS_DRAIN_AGE_EN: saturated-age entries win over any QoS.
module qos_drain_sched #(
  parameter int ID_W   = 4,
  parameter int QOS_W  = 3,
  parameter int DATA_W = 8,
  parameter int AGE_W  = 4
) (
  input logic               clk,
  input logic               rst_n,
  qos_drain_sched_if.slave  bus
);
  localparam int N = 1 << ID_W;

  logic [N-1:0]             r_pend;
  logic [N-1:0][QOS_W-1:0]  r_qos;
  logic [N-1:0][DATA_W-1:0] r_data;
`ifdef QOS_DRAIN_AGE_EN
  logic [N-1:0][AGE_W-1:0]  r_age;
`endif
  logic                     r_ovld;
  logic [ID_W-1:0]          r_oid;
  logic [QOS_W-1:0]         r_oqos;
  logic [DATA_W-1:0]        r_odata;
  logic [ID_W:0]            r_cnt;
  logic [QOS_W-1:0]         r_max;

  logic                     w_acc, w_load, w_found;
  logic [ID_W-1:0]          w_win;
  logic [QOS_W:0]           w_key, w_best;
  logic [N-1:0]             w_pend_nxt;
  logic [QOS_W-1:0]         w_q, w_max_nxt;

  assign bus.in_rdy       = ~r_pend[bus.in_id];
  assign w_acc            = bus.in_vld & bus.in_rdy;
  assign w_load           = w_found & (~r_ovld | bus.out_rdy);
  assign bus.out_vld      = r_ovld;
  assign bus.out_id       = r_oid;
  assign bus.out_qos      = r_oqos;
  assign bus.out_data     = r_odata;
  assign bus.pend_cnt     = r_cnt;
  assign bus.pend_max_qos = r_max;

  // Key MSB marks an aged entry; strict '>' in ascending ID order keeps the lowest ID on ties.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_best  = '0;
    w_key   = '0;
    for (int i = 0; i < N; i++) begin
`ifdef QOS_DRAIN_AGE_EN
      w_key = (&r_age[i]) ? {1'b1, {QOS_W{1'b0}}} : {1'b0, r_qos[i]};
`else
      w_key = {1'b0, r_qos[i]};
`endif
      if (r_pend[i] && (!w_found || w_key > w_best)) begin
        w_found = 1'b1;
        w_best  = w_key;
        w_win   = ID_W'(i);
      end
    end
  end

  // Status registers track the post-edge table, so a new entry shows up one cycle after accept.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_acc)  w_pend_nxt[bus.in_id] = 1'b1;
    if (w_load) w_pend_nxt[w_win]     = 1'b0;
    w_max_nxt = '0;
    w_q       = '0;
    for (int i = 0; i < N; i++) begin
      w_q = (w_acc && bus.in_id == ID_W'(i)) ? bus.in_qos : r_qos[i];
      if (w_pend_nxt[i] && w_q > w_max_nxt) w_max_nxt = w_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_ovld  <= 1'b0;
      r_oid   <= '0;
      r_oqos  <= '0;
      r_odata <= '0;
      r_cnt   <= '0;
      r_max   <= '0;
`ifdef QOS_DRAIN_AGE_EN
      r_age   <= '0;
`endif
    end else begin
      r_pend <= w_pend_nxt;
      r_max  <= w_max_nxt;
      r_cnt  <= r_cnt + {{ID_W{1'b0}}, w_acc} - {{ID_W{1'b0}}, w_load};
      if (w_load) begin
        r_ovld  <= 1'b1;
        r_oid   <= w_win;
        r_oqos  <= r_qos[w_win];
        r_odata <= r_data[w_win];
      end else if (bus.out_rdy) begin
        r_ovld  <= 1'b0;
      end
`ifdef QOS_DRAIN_AGE_EN
      for (int i = 0; i < N; i++) begin
        if (w_acc && bus.in_id == ID_W'(i))
          r_age[i] <= '0;
        else if (r_pend[i] && !(w_load && w_win == ID_W'(i)) && !(&r_age[i]))
          r_age[i] <= r_age[i] + 1'b1;
      end
`endif
    end
  end

  // Payload storage is qualified by the pend bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_qos[bus.in_id]  <= bus.in_qos;
      r_data[bus.in_id] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_qos_drain_sched.sv
// Bench for qos_drain_sched: directed table, hand sequences and random traffic,
// all cross-checked against a per-ID pending-set reference model.
module tb_qos_drain_sched;
  localparam int ID_W = 4, QOS_W = 3, DATA_W = 8, AGE_W = 2;
  localparam int N = 16, AMAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qos_drain_sched_if #(.ID_W(ID_W), .QOS_W(QOS_W), .DATA_W(DATA_W)) bus();
  qos_drain_sched #(.ID_W(ID_W), .QOS_W(QOS_W), .DATA_W(DATA_W), .AGE_W(AGE_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0, bad = 0;
  int cur_id = 0;

  bit m_pend[N];
  int m_qos[N], m_data[N], m_age[N];
  bit m_ov;
  int m_oid, m_oq, m_od;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_age[i] = 0; end
    m_ov = 0; m_oid = 0; m_oq = 0; m_od = 0;
  endfunction

  // Winner: any aged entry (lowest ID) first, otherwise scan QoS high to low, IDs low to high.
  function automatic int mpick();
`ifdef QOS_DRAIN_AGE_EN
    for (int i = 0; i < N; i++) if (m_pend[i] && m_age[i] == AMAX) return i;
`endif
    for (int q = 7; q >= 0; q--)
      for (int i = 0; i < N; i++) if (m_pend[i] && m_qos[i] == q) return i;
    return -1;
  endfunction

  function automatic void mstep(input bit v, input int id, input int q, input int d, input bit r);
    bit acc, ld;
    int w;
    acc = v && !m_pend[id];
    w   = mpick();
    ld  = (w >= 0) && (!m_ov || r);
    for (int i = 0; i < N; i++)
      if (m_pend[i] && !(ld && i == w) && m_age[i] < AMAX) m_age[i]++;
    if (ld) begin
      m_ov = 1; m_oid = w; m_oq = m_qos[w]; m_od = m_data[w]; m_pend[w] = 0;
    end else if (r) m_ov = 0;
    if (acc) begin m_pend[id] = 1; m_qos[id] = q; m_data[id] = d; m_age[id] = 0; end
  endfunction

  task automatic mcmp();
    int c, mx;
    c = 0; mx = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) begin c++; if (m_qos[i] > mx) mx = m_qos[i]; end
    chk("m_in_rdy", int'(bus.in_rdy), int'(!m_pend[cur_id]));
    chk("m_out_vld", int'(bus.out_vld), int'(m_ov));
    if (m_ov) begin
      chk("m_out_id", int'(bus.out_id), m_oid);
      chk("m_out_qos", int'(bus.out_qos), m_oq);
      chk("m_out_data", int'(bus.out_data), m_od);
    end
    chk("m_pend_cnt", int'(bus.pend_cnt), c);
    chk("m_pend_max", int'(bus.pend_max_qos), mx);
  endtask

  // Drive after the edge, check at the falling edge, then advance the model past the next edge.
  task automatic cyc(input bit v, input int id, input int q, input int d, input bit r);
    @(posedge clk); #1;
    bus.in_vld = v; bus.in_id = 4'(id); bus.in_qos = 3'(q); bus.in_data = 8'(d); bus.out_rdy = r;
    cur_id = id;
    @(negedge clk);
    mcmp();
    mstep(v, id, q, d, r);
  endtask

  typedef struct {
    bit v; int id, q, d; bit r;
    bit e_rdy, e_ov; int e_oid, e_cnt, e_max;
  } row_t;
  row_t tbl[7];

  initial begin
    int seen9, nid;
    tbl[0] = '{1, 3, 2, 'h33, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 7, 5, 'h77, 0, 1, 0, 0, 1, 2};
    tbl[2] = '{1, 1, 5, 'h11, 0, 1, 1, 3, 1, 5};
    tbl[3] = '{0, 1, 0, 0,    1, 0, 1, 3, 2, 5};
    tbl[4] = '{0, 1, 0, 0,    1, 1, 1, 1, 1, 5};
    tbl[5] = '{0, 0, 0, 0,    1, 1, 1, 7, 0, 0};
    tbl[6] = '{0, 0, 0, 0,    1, 1, 0, 0, 0, 0};

    bus.in_vld = 0; bus.in_id = 0; bus.in_qos = 0; bus.in_data = 0; bus.out_rdy = 0;
    mreset();
    #12;
    chk("rst_out_vld", int'(bus.out_vld), 0);
    chk("rst_pend_cnt", int'(bus.pend_cnt), 0);
    chk("rst_pend_max", int'(bus.pend_max_qos), 0);
    chk("rst_in_rdy", int'(bus.in_rdy), 1);
    @(negedge clk); rst_n = 1;

    // Priority order
    for (int k = 0; k < 7; k++) begin
      cyc(tbl[k].v, tbl[k].id, tbl[k].q, tbl[k].d, tbl[k].r);
      chk("tbl_in_rdy", int'(bus.in_rdy), int'(tbl[k].e_rdy));
      chk("tbl_out_vld", int'(bus.out_vld), int'(tbl[k].e_ov));
      if (tbl[k].e_ov) chk("tbl_out_id", int'(bus.out_id), tbl[k].e_oid);
      chk("tbl_pend_cnt", int'(bus.pend_cnt), tbl[k].e_cnt);
      chk("tbl_pend_max", int'(bus.pend_max_qos), tbl[k].e_max);
    end

    // Backpressure
    cyc(1, 5, 4, 'hA5, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(k == 0, 2, 7, 'h27, 0);
      chk("bp_hold_id", int'(bus.out_id), 5);
      chk("bp_hold_qos", int'(bus.out_qos), 4);
      chk("bp_hold_data", int'(bus.out_data), 'hA5);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("bp_next_id", int'(bus.out_id), 2);
    chk("bp_next_qos", int'(bus.out_qos), 7);
    cyc(0, 0, 0, 0, 1);

    // Duplicate ID
    cyc(1, 8, 0, 'h80, 0);
    cyc(1, 4, 3, 'h41, 0);
    cyc(1, 4, 6, 'h42, 0);
    chk("dup_blocked", int'(bus.in_rdy), 0);
    cyc(1, 4, 6, 'h42, 1);
    chk("dup_blocked2", int'(bus.in_rdy), 0);
    cyc(1, 4, 6, 'h42, 0);
    chk("dup_reuse_rdy", int'(bus.in_rdy), 1);
    chk("dup_first_data", int'(bus.out_data), 'h41);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("dup_second_id", int'(bus.out_id), 4);
    chk("dup_second_data", int'(bus.out_data), 'h42);
    cyc(0, 0, 0, 0, 1);

    // Counters
    for (int i = 0; i < 16; i++) cyc(1, i, i % 8, i, 0);
    cyc(0, 0, 0, 0, 0);
    chk("cnt_full", int'(bus.pend_cnt), 15);
    chk("cnt_full_max", int'(bus.pend_max_qos), 7);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    chk("cnt_empty", int'(bus.pend_cnt), 0);
    chk("cnt_empty_max", int'(bus.pend_max_qos), 0);
    chk("cnt_empty_vld", int'(bus.out_vld), 0);

    // Reset mid-operation
    for (int i = 10; i < 16; i++) cyc(1, i, i % 8, i, 0);
    cyc(0, 12, 0, 0, 0);
    chk("pre_rst_cnt", int'(bus.pend_cnt), 5);
    chk("pre_rst_vld", int'(bus.out_vld), 1);
    @(posedge clk); #3;
    bus.in_vld = 0; bus.out_rdy = 0;
    rst_n = 0; #1;
    chk("async_rst_vld", int'(bus.out_vld), 0);
    chk("async_rst_cnt", int'(bus.pend_cnt), 0);
    chk("async_rst_rdy", int'(bus.in_rdy), 1);
    mreset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) cyc(0, 12, 0, 0, 1);

    // Aging: id9 q0 behind a steady q7 stream on ids 0/1
    cyc(1, 0, 7, 'h70, 0);
    cyc(1, 9, 0, 'h99, 0);
    cyc(1, 0, 7, 'h71, 0);
    cyc(1, 1, 7, 'h72, 0);
    seen9 = 0;
    for (int k = 0; k < 20; k++) begin
      nid = m_pend[0] ? 1 : 0;
      cyc(1, nid, 7, $urandom_range(0, 255), 1);
      if (bus.out_vld && bus.out_id == 9) seen9++;
    end
`ifdef QOS_DRAIN_AGE_EN
    chk("age_id9_during_stream", seen9, 1);
`else
    chk("age_id9_during_stream", seen9, 0);
`endif
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (bus.out_vld && bus.out_id == 9) seen9++;
    end
    chk("age_id9_total", seen9, 1);

    // Random traffic
    for (int k = 0; k < 1500; k++)
      cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 255), $urandom_range(0, 3) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
